// File: rtl/glyph_serializer_pkg.sv
// Shared constants and state encoding for the text-mode glyph path
// (character fetcher, glyph serializer, font RAM wrapper).
// No ports; imported by the interface and the serializer.
package glyph_serializer_pkg;

    localparam int CHAR_WIDTH    = 16;               // pixels per glyph row
    localparam int ROWS_PER_CHAR = 20;               // glyph rows per character
    localparam int CHARS         = 1024;             // glyphs held in font RAM
    localparam int CODE_WIDTH    = $clog2(CHARS);
    localparam int ROW_WIDTH     = 5;
    localparam int RAM_WIDTH     = 15;               // font RAM address width
    localparam int COLOR_WIDTH   = 4;                // palette index width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Row-major glyph address. Truncating the operands before the multiply
    // gives the same low RAM_WIDTH bits as the full-width product.
    function automatic logic [RAM_WIDTH-1:0] glyph_address(
        input logic [CODE_WIDTH-1:0] code,
        input logic [ROW_WIDTH-1:0]  row
    );
        return RAM_WIDTH'(code) * RAM_WIDTH'(ROWS_PER_CHAR) + RAM_WIDTH'(row);
    endfunction

endpackage

// File: rtl/glyph_serializer_if.sv
// Glyph serializer bus: request from the character fetcher, address/data
// to and from the font RAM, and the pixel stream to the colour stage.
// master : character fetcher / font RAM / pixel sink side (drives requests,
//          bitmap and pixel_ready)
// slave  : glyph serializer side
interface glyph_serializer_if;
    import glyph_serializer_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [CODE_WIDTH-1:0]  char_code;
    logic [ROW_WIDTH-1:0]   char_row;
    logic [COLOR_WIDTH-1:0] fg_color;
    logic [COLOR_WIDTH-1:0] bg_color;
    logic                   invert;
    logic [RAM_WIDTH-1:0]   font_address;
    logic [CHAR_WIDTH-1:0]  char_row_bitmap;
    logic                   pixel_valid;
    logic                   pixel_ready;
    logic [COLOR_WIDTH-1:0] pixel_color;
    logic                   pixel_last;

    modport master (
        output req_valid, char_code, char_row, fg_color, bg_color, invert,
               char_row_bitmap, pixel_ready,
        input  req_ready, font_address, pixel_valid, pixel_color, pixel_last
    );

    modport slave (
        input  req_valid, char_code, char_row, fg_color, bg_color, invert,
               char_row_bitmap, pixel_ready,
        output req_ready, font_address, pixel_valid, pixel_color, pixel_last
    );

endinterface

// File: rtl/glyph_serializer.sv
// Glyph serializer: turns one (char code, glyph row, colours) request into a
// font RAM address, captures the returned row bitmap and emits it one pixel
// per accepted beat, MSB (leftmost pixel) first.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    glyph_serializer_if.slave (request, font RAM, pixel stream)
// Parameter:
//   RAM_LATENCY  clk edges from address to valid bitmap at the font RAM (>=1)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a request, req_ready=1
// ST_FETCH | address out, counting down font RAM latency, then load bitmap
// ST_SHIFT | streaming pixels; last beat may accept the next request
module glyph_serializer
    import glyph_serializer_pkg::*;
#(
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    glyph_serializer_if.slave bus
);

    localparam int CNT_W = $clog2(RAM_LATENCY + 1);
    localparam int IDX_W = $clog2(CHAR_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAR_WIDTH - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CHAR_WIDTH-1:0]  shift_q;
    logic [IDX_W-1:0]       idx_q;
    logic [COLOR_WIDTH-1:0] fg_q, bg_q;
    logic                   blank_q;
    logic                   pixel_valid_q;
    logic [RAM_WIDTH-1:0]   font_address_q;
    logic                   last_xfer;
    logic                   accept;
    logic                   load;

    assign last_xfer = (state_q == ST_SHIFT) && bus.pixel_ready && (idx_q == LAST_IDX);
    assign load      = (state_q == ST_FETCH) && (cnt_q == '0);
    assign accept    = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.req_valid) state_d = ST_FETCH;
            ST_FETCH: if (cnt_q == '0)   state_d = ST_SHIFT;
            ST_SHIFT: if (last_xfer)     state_d = bus.req_valid ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = (state_q == ST_IDLE) || last_xfer;
        bus.pixel_color  = '0;
        bus.pixel_last   = 1'b0;
        if (pixel_valid_q) begin
            bus.pixel_color = shift_q[CHAR_WIDTH-1] ? fg_q : bg_q;
            bus.pixel_last  = (idx_q == LAST_IDX);
        end
    end

    assign bus.font_address = font_address_q;
    assign bus.pixel_valid  = pixel_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            shift_q        <= '0;
            idx_q          <= '0;
            fg_q           <= '0;
            bg_q           <= '0;
            blank_q        <= 1'b0;
            pixel_valid_q  <= 1'b0;
            font_address_q <= '0;
        end else if (accept) begin
            font_address_q <= glyph_address(bus.char_code, bus.char_row);
            // invert is folded into the latched colours so the pixel mux stays simple
            fg_q           <= bus.invert ? bus.bg_color : bus.fg_color;
            bg_q           <= bus.invert ? bus.fg_color : bus.bg_color;
            blank_q        <= (32'(bus.char_row) >= ROWS_PER_CHAR);
            cnt_q          <= CNT_W'(RAM_LATENCY);
            pixel_valid_q  <= 1'b0;
            idx_q          <= '0;
        end else if (load) begin
            shift_q       <= blank_q ? '0 : bus.char_row_bitmap;
            pixel_valid_q <= 1'b1;
            idx_q         <= '0;
        end else if (state_q == ST_FETCH) begin
            cnt_q <= cnt_q - 1'b1;
        end else if (state_q == ST_SHIFT && bus.pixel_ready) begin
            shift_q <= shift_q << 1;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) pixel_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_glyph_serializer.sv
module tb_glyph_serializer;
    import glyph_serializer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    glyph_serializer_if bus();
    glyph_serializer #(.RAM_LATENCY(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // font RAM model: one registered stage
    logic        use_forced = 1'b0;
    logic [15:0] forced_word = 16'h0;
    logic [31:0] seed = 32'h1234_5678;
    logic [15:0] ram_q = 16'h0;

    function automatic logic [15:0] mem_word(input logic [14:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'h0000_9E37 + seed;
        return use_forced ? forced_word : (t[15:0] ^ t[31:16]);
    endfunction

    always @(posedge clk) ram_q <= mem_word(bus.font_address);
    assign bus.char_row_bitmap = ram_q;

    // expected row from the rules: address arithmetic, blank rows, colour swap
    int          exp_addr;
    logic [3:0]  exp_col[16];
    logic        exp_last[16];

    task automatic build_expected(input int code, input int row, input logic [3:0] fg,
                                  input logic [3:0] bg, input logic inv);
        logic [15:0] bm;
        logic [3:0]  on, off;
        exp_addr = (code * 20 + row) % 32768;
        bm  = (row >= 20) ? 16'h0 : mem_word(15'(exp_addr));
        on  = inv ? bg : fg;
        off = inv ? fg : bg;
        for (int i = 0; i < 16; i++) begin
            exp_col[i]  = bm[15 - i] ? on : off;
            exp_last[i] = (i == 15);
        end
    endtask

    // observed row
    logic [3:0] got_col[16];
    logic       got_last[16];
    int n_got, first_edge, last_edge, hold_err, acc_cnt, acc_on_last;

    task automatic send_req(input int code, input int row, input logic [3:0] fg,
                            input logic [3:0] bg, input logic inv);
        bit done = 0;
        bus.char_code = 10'(code);
        bus.char_row  = 5'(row);
        bus.fg_color  = fg;
        bus.bg_color  = bg;
        bus.invert    = inv;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) done = 1;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_req accept: req_ready=0, required 1 within 50 cycles");
        end
    endtask

    // mode 0: ready always, 1: ready toggles starting high, 2: random ready
    task automatic collect_row(input int mode, input int stop_after, input int flip_at);
        int cycles = 0;
        bit have_prev = 0, drop = 0;
        logic [3:0] prev_col = '0;
        n_got = 0; first_edge = -1; last_edge = -1; hold_err = 0;
        acc_cnt = 0; acc_on_last = 0;
        while (n_got < stop_after && cycles < 300) begin
            case (mode)
                0: bus.pixel_ready = 1'b1;
                1: bus.pixel_ready = (cycles % 2 == 0);
                default: bus.pixel_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) begin
                acc_cnt++;
                if (bus.pixel_valid && bus.pixel_ready && bus.pixel_last) acc_on_last++;
                drop = 1;
            end
            if (bus.pixel_valid) begin
                if (first_edge < 0) first_edge = cycles;
                if (have_prev && bus.pixel_color !== prev_col) hold_err++;
                if (bus.pixel_ready) begin
                    got_col[n_got]  = bus.pixel_color;
                    got_last[n_got] = bus.pixel_last;
                    n_got++;
                    last_edge = cycles;
                    have_prev = 0;
                    if (n_got == flip_at) forced_word = ~forced_word;
                end else begin
                    have_prev = 1;
                    prev_col  = bus.pixel_color;
                end
            end
            @(posedge clk); #1;
            cycles++;
            if (drop) begin bus.req_valid = 1'b0; drop = 0; end
        end
        bus.pixel_ready = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL reset pixel_valid: got %b want 0", bus.pixel_valid); end
        checks++; if (bus.font_address !== 15'd0) begin errors++; $display("FAIL reset font_address: got %0d want 0", bus.font_address); end
        checks++; if (bus.pixel_color !== 4'd0 || bus.pixel_last !== 1'b0) begin errors++; $display("FAIL reset pixel_color/last: got %h/%b want 0/0", bus.pixel_color, bus.pixel_last); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input logic inv);
        use_forced = 1'b1; forced_word = 16'h8001;
        build_expected(16'h041, 3, 4'hF, 4'h1, inv);
        send_req(16'h041, 3, 4'hF, 4'h1, inv);
        checks++; if (bus.font_address !== 15'(exp_addr) || exp_addr != 1303) begin errors++; $display("FAIL basic font_address: got %0d want 1303", bus.font_address); end
        collect_row(0, 16, -1);
        checks++; if (n_got != 16 || first_edge != 2) begin errors++; $display("FAIL basic latency: got %0d pixels first at edge %0d want 16 at 2", n_got, first_edge); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_col[i] !== exp_col[i] || got_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL basic inv=%0b pixel %0d: got %h/%b want %h/%b", inv, i, got_col[i], got_last[i], exp_col[i], exp_last[i]);
            end
        end
        @(negedge clk);
        checks++; if (bus.pixel_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL basic idle after row: valid=%b ready=%b want 0/1", bus.pixel_valid, bus.req_ready); end
        @(posedge clk); #1;
        use_forced = 1'b0;
    endtask

    task automatic test_boundary;
        build_expected(1023, 19, 4'h7, 4'h2, 1'b0);
        send_req(1023, 19, 4'h7, 4'h2, 1'b0);
        checks++; if (bus.font_address !== 15'd20479) begin errors++; $display("FAIL boundary last row address: got %0d want 20479", bus.font_address); end
        collect_row(0, 16, -1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_col[i] !== exp_col[i]) begin errors++; $display("FAIL boundary row19 pixel %0d: got %h want %h", i, got_col[i], exp_col[i]); end
        end
        use_forced = 1'b1; forced_word = 16'hFFFF;
        for (int v = 0; v < 2; v++) begin
            send_req(1023, 20, 4'h7, 4'h2, 1'(v));
            checks++; if (bus.font_address !== 15'd20480) begin errors++; $display("FAIL boundary row20 address: got %0d want 20480", bus.font_address); end
            collect_row(0, 16, -1);
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_col[i] !== (v ? 4'h7 : 4'h2)) begin errors++; $display("FAIL boundary row20 inv=%0d pixel %0d: got %h want %h", v, i, got_col[i], v ? 4'h7 : 4'h2); end
            end
        end
        use_forced = 1'b0;
    endtask

    task automatic test_stall;
        use_forced = 1'b1; forced_word = 16'hA5C3;
        build_expected(77, 5, 4'hC, 4'h3, 1'b0);
        send_req(77, 5, 4'hC, 4'h3, 1'b0);
        collect_row(1, 16, 6);   // bitmap input changes mid-row must not matter
        checks++; if (n_got != 16 || last_edge - first_edge != 30) begin errors++; $display("FAIL stall span: got %0d pixels over %0d edges want 16 over 30", n_got, last_edge - first_edge); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL stall hold: got %0d colour changes while stalled want 0", hold_err); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_col[i] !== exp_col[i] || got_last[i] !== exp_last[i]) begin errors++; $display("FAIL stall pixel %0d: got %h/%b want %h/%b", i, got_col[i], got_last[i], exp_col[i], exp_last[i]); end
        end
        use_forced = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 3; r++) begin
            int c1 = $urandom_range(0, 1023), c2 = $urandom_range(0, 1023);
            int w1 = $urandom_range(0, 19),   w2 = $urandom_range(0, 19);
            build_expected(c1, w1, 4'h9, 4'h4, 1'b0);
            send_req(c1, w1, 4'h9, 4'h4, 1'b0);
            bus.char_code = 10'(c2); bus.char_row = 5'(w2);
            bus.fg_color = 4'hE; bus.bg_color = 4'h0; bus.invert = 1'b1;
            bus.req_valid = 1'b1;
            collect_row(2, 16, -1);
            bus.req_valid = 1'b0;
            checks++; if (acc_cnt != 1 || acc_on_last != 1) begin errors++; $display("FAIL b2b accept: got %0d accepts (%0d on last) want 1 on last", acc_cnt, acc_on_last); end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_col[i] !== exp_col[i] || got_last[i] !== exp_last[i]) begin errors++; $display("FAIL b2b row1 pixel %0d: got %h/%b want %h/%b", i, got_col[i], got_last[i], exp_col[i], exp_last[i]); end
            end
            build_expected(c2, w2, 4'hE, 4'h0, 1'b1);
            checks++; if (bus.font_address !== 15'(exp_addr)) begin errors++; $display("FAIL b2b row2 address: got %0d want %0d", bus.font_address, exp_addr); end
            collect_row(0, 16, -1);
            checks++; if (n_got != 16 || first_edge != 2) begin errors++; $display("FAIL b2b row2 latency: got %0d pixels first at %0d want 16 at 2", n_got, first_edge); end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_col[i] !== exp_col[i] || got_last[i] !== exp_last[i]) begin errors++; $display("FAIL b2b row2 pixel %0d: got %h/%b want %h/%b", i, got_col[i], got_last[i], exp_col[i], exp_last[i]); end
            end
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            int c = $urandom_range(0, 1023), w = $urandom_range(0, 23);
            logic [3:0] f = 4'($urandom), b = 4'($urandom);
            logic v = 1'($urandom);
            seed = $urandom;
            build_expected(c, w, f, b, v);
            send_req(c, w, f, b, v);
            checks++; if (bus.font_address !== 15'(exp_addr)) begin errors++; $display("FAIL random address: got %0d want %0d", bus.font_address, exp_addr); end
            collect_row(2, 16, -1);
            checks++; if (hold_err != 0 || n_got != 16) begin errors++; $display("FAIL random flow: got %0d pixels %0d hold errors want 16/0", n_got, hold_err); end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got_col[i] !== exp_col[i] || got_last[i] !== exp_last[i]) begin errors++; $display("FAIL random row %0d pixel %0d: got %h/%b want %h/%b", r, i, got_col[i], got_last[i], exp_col[i], exp_last[i]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        send_req(300, 7, 4'hB, 4'h5, 1'b0);
        collect_row(0, 7, -1);
        reset = 1'b1;
        #1;
        checks++; if (bus.pixel_valid !== 1'b0 || bus.pixel_last !== 1'b0 || bus.pixel_color !== 4'h0) begin errors++; $display("FAIL reset_mid outputs: got valid=%b last=%b color=%h want 0/0/0", bus.pixel_valid, bus.pixel_last, bus.pixel_color); end
        checks++; if (bus.font_address !== 15'd0) begin errors++; $display("FAIL reset_mid font_address: got %0d want 0", bus.font_address); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid req_ready: got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
        build_expected(512, 11, 4'h6, 4'hA, 1'b0);
        send_req(512, 11, 4'h6, 4'hA, 1'b0);
        collect_row(0, 16, -1);
        checks++; if (n_got != 16 || first_edge != 2) begin errors++; $display("FAIL reset_mid restart: got %0d pixels first at %0d want 16 at 2", n_got, first_edge); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_col[i] !== exp_col[i] || got_last[i] !== exp_last[i]) begin errors++; $display("FAIL reset_mid pixel %0d: got %h/%b want %h/%b", i, got_col[i], got_last[i], exp_col[i], exp_last[i]); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.char_code = '0;
        bus.char_row  = '0;
        bus.fg_color  = '0;
        bus.bg_color  = '0;
        bus.invert    = 1'b0;
        bus.pixel_ready = 1'b1;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_boundary();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
